// File: rtl/vga_tile_renderer.sv
// VGA raster timing plus a three-stage tile-map pixel pipeline with a writable 16-entry palette.
// Optional build macro VGA_TILE_GRID_LINES_EN overlays tile-boundary grid lines using palette entry 15.
module vga_tile_renderer #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 18,
  parameter int H_SYNC     = 92,
  parameter int H_BACK     = 50,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int TILE_SHIFT = 5,
  parameter int GRID_W     = 20,
  parameter int GRID_H     = 15,
  parameter int IDX_BITS   = 4,
  parameter int COLOR_BITS = 3,
  parameter int ADDR_W     = 9
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  output logic [ADDR_W-1:0]       o_Tile_Addr,
  input  logic [IDX_BITS-1:0]     i_Tile_Data,
  input  logic                    i_Pal_We,
  input  logic [IDX_BITS-1:0]     i_Pal_Idx,
  input  logic [3*COLOR_BITS-1:0] i_Pal_Rgb,
  output logic                    o_VGA_HSync,
  output logic                    o_VGA_VSync,
  output logic [COLOR_BITS-1:0]   o_VGA_Red,
  output logic [COLOR_BITS-1:0]   o_VGA_Grn,
  output logic [COLOR_BITS-1:0]   o_VGA_Blu,
  output logic                    o_Frame_Start
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int CW = 3 * COLOR_BITS;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_DISPLAY);
  localparam logic [HW-1:0] HS_BEG = HW'(H_DISPLAY + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_DISPLAY);
  localparam logic [VW-1:0] VS_BEG = VW'(V_DISPLAY + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [HW-1:0] COL_LIM = HW'(GRID_W);
  localparam logic [VW-1:0] ROW_LIM = VW'(GRID_H);

  // Reset palette as 3-digit octal RGB; digit 7 = full scale, 4 = half scale (MSB only).
  localparam logic [8:0] PAL_CODE [16] = '{
    9'o700, 9'o070, 9'o007, 9'o770, 9'o707, 9'o077, 9'o440, 9'o404,
    9'o044, 9'o740, 9'o470, 9'o074, 9'o704, 9'o407, 9'o047, 9'o777};

  function automatic logic [COLOR_BITS-1:0] level(input logic [2:0] d);
    level = '0;
    if (d == 3'd7) level = '1;
    else if (d == 3'd4) level[COLOR_BITS-1] = 1'b1;
  endfunction

  function automatic logic [CW-1:0] pal_default(input logic [3:0] idx);
    logic [8:0] code;
    code = PAL_CODE[idx];
    pal_default = {level(code[8:6]), level(code[5:3]), level(code[2:0])};
  endfunction

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [HW-1:0]     col;
  logic [VW-1:0]     row;
  logic              active_raw, hs_raw, vs_raw, oog_raw, fs_raw;
  logic [ADDR_W-1:0] addr_raw;
  logic              act1, hs1, vs1, oog1, fs1;
  logic              act2, hs2, vs2, oog2, fs2;
  logic [CW-1:0]     pal [16];
  logic [CW-1:0]     pix;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    col        = h_cnt >> TILE_SHIFT;
    row        = v_cnt >> TILE_SHIFT;
    active_raw = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_raw     = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs_raw     = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    oog_raw    = (col >= COL_LIM) || (row >= ROW_LIM);
    fs_raw     = (h_cnt == '0) && (v_cnt == '0);
    addr_raw   = ADDR_W'(int'(row) * GRID_W + int'(col));
  end

  // Stage 2 is the memory's own output register: i_Tile_Data lines up with the *2 flags.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Tile_Addr <= '0;
      act1 <= 1'b0; hs1 <= 1'b1; vs1 <= 1'b1; oog1 <= 1'b0; fs1 <= 1'b0;
      act2 <= 1'b0; hs2 <= 1'b1; vs2 <= 1'b1; oog2 <= 1'b0; fs2 <= 1'b0;
    end else begin
      o_Tile_Addr <= addr_raw;
      act1 <= active_raw; hs1 <= hs_raw; vs1 <= vs_raw; oog1 <= oog_raw; fs1 <= fs_raw;
      act2 <= act1;       hs2 <= hs1;    vs2 <= vs1;    oog2 <= oog1;    fs2 <= fs1;
    end
  end

`ifdef VGA_TILE_GRID_LINES_EN
  logic gl_raw, gl1, gl2;
  assign gl_raw = (h_cnt[TILE_SHIFT-1:0] == '0) || (v_cnt[TILE_SHIFT-1:0] == '0);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      gl1 <= 1'b0;
      gl2 <= 1'b0;
    end else begin
      gl1 <= gl_raw;
      gl2 <= gl1;
    end
  end

  always_comb begin
    pix = '0;
    if (act2 && gl2) pix = pal[4'hF];
    else if (act2 && !oog2) pix = pal[i_Tile_Data];
  end
`else
  always_comb begin
    pix = '0;
    if (act2 && !oog2) pix = pal[i_Tile_Data];
  end
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_VGA_Red     <= '0;
      o_VGA_Grn     <= '0;
      o_VGA_Blu     <= '0;
      o_VGA_HSync   <= 1'b1;
      o_VGA_VSync   <= 1'b1;
      o_Frame_Start <= 1'b0;
    end else begin
      {o_VGA_Red, o_VGA_Grn, o_VGA_Blu} <= pix;
      o_VGA_HSync   <= hs2;
      o_VGA_VSync   <= vs2;
      o_Frame_Start <= fs2;
    end
  end

  // A lookup in the same clock as a write still sees the old entry.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < 16; i++) pal[i] <= pal_default(4'(i));
    end else if (i_Pal_We) begin
      pal[i_Pal_Idx] <= i_Pal_Rgb;
    end
  end
endmodule

// File: tb/tb_vga_tile_renderer.sv
// Bench for vga_tile_renderer on a reduced raster (156x73 clocks, 16 px tiles, 6x3 grid)
// so several frames fit in a short run; expected outputs come from a raster-position model.
module tb_vga_tile_renderer;
  localparam int HD = 128, HF = 6, HS = 12, HB = 10;
  localparam int VD = 64,  VF = 3, VS = 2,  VB = 4;
  localparam int TS = 4, GW = 6, GH = 3, IB = 4, CB = 3, AW = 5;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int RST_B = FRAME + 20 * HT + 50;
`ifdef VGA_TILE_GRID_LINES_EN
  localparam bit GL = 1'b1;
`else
  localparam bit GL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] o_Tile_Addr;
  logic [IB-1:0] tile_data;
  logic          pal_we;
  logic [IB-1:0] pal_idx;
  logic [8:0]    pal_rgb;
  logic          o_VGA_HSync, o_VGA_VSync, o_Frame_Start;
  logic [CB-1:0] o_VGA_Red, o_VGA_Grn, o_VGA_Blu;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_tile_renderer #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .TILE_SHIFT(TS), .GRID_W(GW), .GRID_H(GH), .IDX_BITS(IB),
    .COLOR_BITS(CB), .ADDR_W(AW)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .o_Tile_Addr(o_Tile_Addr), .i_Tile_Data(tile_data),
    .i_Pal_We(pal_we), .i_Pal_Idx(pal_idx), .i_Pal_Rgb(pal_rgb),
    .o_VGA_HSync(o_VGA_HSync), .o_VGA_VSync(o_VGA_VSync),
    .o_VGA_Red(o_VGA_Red), .o_VGA_Grn(o_VGA_Grn), .o_VGA_Blu(o_VGA_Blu),
    .o_Frame_Start(o_Frame_Start)
  );

  // Synchronous tile memory: data for an address appears one clock later.
  logic [IB-1:0] mem [32];
  always @(posedge clk) tile_data <= mem[o_Tile_Addr];

  function automatic logic [8:0] pal_def(input int i);
    case (i)
      0: return 9'o700;  1: return 9'o070;  2: return 9'o007;  3: return 9'o770;
      4: return 9'o707;  5: return 9'o077;  6: return 9'o440;  7: return 9'o404;
      8: return 9'o044;  9: return 9'o740; 10: return 9'o470; 11: return 9'o074;
      12: return 9'o704; 13: return 9'o407; 14: return 9'o047; default: return 9'o777;
    endcase
  endfunction

  int         cyc;
  logic [8:0] pal_m [16];
  logic [AW-1:0] e_addr;
  logic [8:0] e_rgb;
  logic       e_hs, e_vs, e_fs;

  // Expected address for raster position p (clocks since reset release).
  function automatic logic [AW-1:0] exp_addr(input int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    return AW'((v >> TS) * GW + (h >> TS));
  endfunction

  // Expected {hsync, vsync, frame_start, rgb} for raster position p; p < 0 means pipeline still empty.
  function automatic logic [11:0] exp_pix(input int p);
    int h, v;
    logic act, hs, vs, fs;
    logic [8:0] c;
    if (p < 0) return {1'b1, 1'b1, 1'b0, 9'd0};
    h   = p % HT;
    v   = (p / HT) % VT;
    act = (h < HD) && (v < VD);
    hs  = !(h >= HD + HF && h < HD + HF + HS);
    vs  = !(v >= VD + VF && v < VD + VF + VS);
    fs  = (h == 0) && (v == 0);
    c   = 9'd0;
    if (act && (h >> TS) < GW && (v >> TS) < GH) c = pal_m[mem[(v >> TS) * GW + (h >> TS)]];
    if (GL && act && ((h % (1 << TS)) == 0 || (v % (1 << TS)) == 0)) c = pal_m[15];
    return {hs, vs, fs, c};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc    <= 0;
      e_addr <= '0;
      e_rgb  <= '0;
      e_hs   <= 1'b1;
      e_vs   <= 1'b1;
      e_fs   <= 1'b0;
      for (int i = 0; i < 16; i++) pal_m[i] <= pal_def(i);
    end else begin
      cyc    <= cyc + 1;
      e_addr <= exp_addr(cyc);
      {e_hs, e_vs, e_fs, e_rgb} <= exp_pix(cyc - 2);
      if (pal_we) pal_m[pal_idx] <= pal_rgb;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("addr",   32'(o_Tile_Addr), 32'(e_addr));
    chk("rgb",    32'({o_VGA_Red, o_VGA_Grn, o_VGA_Blu}), 32'(e_rgb));
    chk("hsync",  32'(o_VGA_HSync), 32'(e_hs));
    chk("vsync",  32'(o_VGA_VSync), 32'(e_vs));
    chk("fstart", 32'(o_Frame_Start), 32'(e_fs));
  end

  task automatic run_to(input int c);
    int g;
    g = 0;
    while (cyc < c && g < 200000) begin
      @(negedge clk);
      g++;
    end
    chk("run_to", 32'(cyc), 32'(c));
  endtask

  task automatic chk_reset_vals();
    chk("rst_addr",  32'(o_Tile_Addr), 32'd0);
    chk("rst_rgb",   32'({o_VGA_Red, o_VGA_Grn, o_VGA_Blu}), 32'd0);
    chk("rst_hsync", 32'(o_VGA_HSync), 32'd1);
    chk("rst_vsync", 32'(o_VGA_VSync), 32'd1);
    chk("rst_fs",    32'(o_Frame_Start), 32'd0);
  endtask

  function automatic logic [31:0] rgb_now();
    return 32'({o_VGA_Red, o_VGA_Grn, o_VGA_Blu});
  endfunction

  initial begin
    int hs_lo, vs_lo, fs_n;
    rst_n = 1'b0; pal_we = 1'b0; pal_idx = '0; pal_rgb = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[0] = 4'h2;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    #2 rst_n = 1'b1;

    run_to(2);   chk("fs_early", 32'(o_Frame_Start), 32'd0);
    run_to(3);   chk("fs_first", 32'(o_Frame_Start), 32'd1);
                 chk("px_0_0", rgb_now(), GL ? 32'o777 : 32'o007);
    run_to(17);  chk("addr_h16", 32'(o_Tile_Addr), 32'd1);
    run_to(19);  chk("px_16_0", rgb_now(), GL ? 32'o777 : 32'o700);
    run_to(96);  chk("addr_h95", 32'(o_Tile_Addr), 32'd5);
    run_to(133); chk("px_blank", rgb_now(), 32'd0);
    run_to(136); chk("hs_before", 32'(o_VGA_HSync), 32'd1);
    run_to(137); chk("hs_start", 32'(o_VGA_HSync), 32'd0);
    run_to(148); chk("hs_last", 32'(o_VGA_HSync), 32'd0);
    run_to(149); chk("hs_after", 32'(o_VGA_HSync), 32'd1);
    run_to(160); chk("px_1_1", rgb_now(), 32'o007);
    run_to(176); chk("px_17_1", rgb_now(), 32'o700);
    run_to(259); chk("px_oog", rgb_now(), 32'd0);

    run_to(790);
    pal_we = 1'b1; pal_idx = 4'd2; pal_rgb = 9'b111_111_000;
    run_to(791); chk("pal_old", rgb_now(), 32'o007);
    pal_we = 1'b0;
    run_to(792); chk("pal_new", rgb_now(), 32'o770);

    run_to(2497);  chk("addr_row1", 32'(o_Tile_Addr), 32'd6);
    run_to(7428);  chk("addr_last", 32'(o_Tile_Addr), 32'd17);
    run_to(10454); chk("vs_before", 32'(o_VGA_VSync), 32'd1);
    run_to(10455); chk("vs_start", 32'(o_VGA_VSync), 32'd0);
    run_to(FRAME + 2); chk("fs2_early", 32'(o_Frame_Start), 32'd0);
    run_to(FRAME + 3); chk("fs2", 32'(o_Frame_Start), 32'd1);

    hs_lo = 0; vs_lo = 0; fs_n = 0;
    for (int i = 0; i < FRAME; i++) begin
      run_to(FRAME + 3 + i);
      if (!o_VGA_HSync) hs_lo++;
      if (!o_VGA_VSync) vs_lo++;
      if (o_Frame_Start) fs_n++;
    end
    chk("hs_count", 32'(hs_lo), 32'(HS * VT));
    chk("vs_count", 32'(vs_lo), 32'(VS * HT));
    chk("fs_count", 32'(fs_n), 32'd1);

    // Random tile map and random palette writes, then a mid-frame reset.
    #2 rst_n = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 4'($urandom_range(0, 15));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int c = 1; c < RST_B - 1; c++) begin
      run_to(c);
      pal_we  = ($urandom_range(0, 7) == 0);
      pal_idx = 4'($urandom_range(0, 15));
      pal_rgb = 9'($urandom_range(0, 511));
    end
    run_to(RST_B - 1);
    pal_we = 1'b1; pal_idx = 4'd5; pal_rgb = 9'o123;
    run_to(RST_B);
    pal_we = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    for (int i = 0; i < 32; i++) mem[i] = 4'($urandom_range(0, 15));
    mem[0] = 4'd5;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run_to(2);   chk("rfs_early", 32'(o_Frame_Start), 32'd0);
    run_to(3);   chk("rfs_first", 32'(o_Frame_Start), 32'd1);
    run_to(160); chk("pal5_default", rgb_now(), 32'o077);
    for (int c = 161; c < FRAME + 200; c++) begin
      run_to(c);
      pal_we  = ($urandom_range(0, 5) == 0);
      pal_idx = 4'($urandom_range(0, 15));
      pal_rgb = 9'($urandom_range(0, 511));
    end
    pal_we = 1'b0;
    run_to(FRAME + 210);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_tile_renderer.md
Name: vga_tile_renderer

Overview:
- Parametrised VGA timing generator and tile-map pixel pipeline.
- Walks the raster, fetches a palette index per tile from external synchronous tile memory (BRAM), maps it through a writable 16-entry palette, and drives registered RGB plus HSync/VSync.
- Successor to the fixed 640x480 tile display: configurable timing and grid, reset, a pipeline-aligned sync path, a writable palette and a frame-start strobe.

Parameters:
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 18, horizontal front porch (clocks)
- H_SYNC, 92, horizontal sync width
- H_BACK, 50, horizontal back porch
- V_DISPLAY, 480, active lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- TILE_SHIFT, 5, log2 of tile edge in pixels (32 px tiles)
- GRID_W, 20, tiles per row
- GRID_H, 15, tile rows
- IDX_BITS, 4, palette index width
- COLOR_BITS, 3, bits per colour channel
- ADDR_W, 9, tile address width; must satisfy 2^ADDR_W >= GRID_W*GRID_H

Ports:
- i_Clk  in  1  pixel clock (25 MHz)
- i_Rst_n  in  1  asynchronous active-low reset
- o_Tile_Addr  out  ADDR_W  tile memory read address, registered
- i_Tile_Data  in  IDX_BITS  tile memory read data, valid 1 clock after o_Tile_Addr
- i_Pal_We  in  1  palette write enable
- i_Pal_Idx  in  IDX_BITS  palette entry to write
- i_Pal_Rgb  in  3*COLOR_BITS  {R,G,B} value to write
- o_VGA_HSync  out  1  horizontal sync, active low
- o_VGA_VSync  out  1  vertical sync, active low
- o_VGA_Red  out  COLOR_BITS  red
- o_VGA_Grn  out  COLOR_BITS  green
- o_VGA_Blu  out  COLOR_BITS  blue
- o_Frame_Start  out  1  one-clock pulse aligned with the first active pixel of a frame

Behaviour:
- Clock and reset: one clock domain, i_Clk. i_Rst_n is asynchronous and active-low.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800).
  - v_cnt runs 0..V_TOTAL-1 (525) and advances when h_cnt wraps.
  - Both wrap to 0. Order within a line or frame: active, front porch, sync, back porch.
- Raw timing signals:
  - Active when h_cnt < H_DISPLAY and v_cnt < V_DISPLAY.
  - hsync_raw is low for H_DISPLAY+H_FRONT <= h_cnt < H_DISPLAY+H_FRONT+H_SYNC.
  - vsync_raw is defined the same way on v_cnt.
- Stage 1 (t+1):
  - col = h_cnt>>TILE_SHIFT, row = v_cnt>>TILE_SHIFT.
  - o_Tile_Addr <= row*GRID_W + col, truncated to ADDR_W.
  - An out-of-grid flag is registered when col >= GRID_W or row >= GRID_H.
- Stage 2 (t+2): i_Tile_Data is captured.
- Stage 3 (t+3): palette[i_Tile_Data] is registered onto the RGB outputs.
  - RGB is forced to 0 when the delayed active flag is low or the delayed out-of-grid flag is set.
- Alignment:
  - Active, hsync and vsync are delayed 3 clocks so sync and colour stay aligned.
  - Total latency from counter position to pins is 3 clocks.
- o_Frame_Start: high for one clock when the delayed position equals (0,0).
- Palette:
  - 16 x 3*COLOR_BITS registers, written on i_Clk when i_Pal_We is high.
  - A write takes effect for pixels whose stage-3 lookup happens in the next clock or later. A same-cycle lookup of the written entry returns the old value.
  - Writes are accepted at any time, including during active video.
  - Reset contents by index:
    - 0 red 700, 1 green 070, 2 blue 007, 3 yellow 770
    - 4 magenta 707, 5 cyan 077, 6 olive 440, 7 purple 404
    - 8 teal 044, 9 orange 740, 10 lime 470, 11 aqua 074
    - 12 pink 704, 13 violet 407, 14 sky 047, 15 white 777
- Reset state (asserted at any time, including mid-frame):
  - h_cnt=0, v_cnt=0, pipeline cleared.
  - o_Tile_Addr=0, RGB=0, o_VGA_HSync=1, o_VGA_VSync=1, o_Frame_Start=0, palette at default values.
  - After release, the first o_Frame_Start occurs exactly 3 clocks later.
- Simultaneous h and v wrap: v_cnt goes to 0 on the same clock that h_cnt goes to 0.

Optional Feature:
- Macro: VGA_TILE_GRID_LINES_EN.
- When defined: during active video, any pixel whose h or v low TILE_SHIFT bits are all zero is drawn with palette entry 15 instead of the tile colour. The substitution is made at stage 3 and latency is unchanged.
- When undefined: no grid lines; tile colour only.

Test Plan:
- Timing: reset, then run 2 frames. HSync is low for exactly 92 of every 800 clocks. VSync is low for exactly 2 of 525 lines. o_Frame_Start pulses every 420000 clocks.
- Address walk:
  - Line 0: o_Tile_Addr=0 for h 0..31, then 1 at h 32, and 19 at h 608..639.
  - Line 32: o_Tile_Addr=20 at h 0.
  - Line 479: o_Tile_Addr=299 at h 639.
- Latency: memory model returns 4'h2 at addr 0 and 4'h0 elsewhere. The first frame pixel shows RGB 000/000/111 exactly 3 clocks after counter (0,0). Pixel 32 shows 111/000/000. Blanking shows 0/0/0.
- Palette write: write idx 2 <= 9'b111_111_000 mid-line. Tile-2 pixels looked up from the next clock on show 111/111/000; earlier ones show blue.
- Reset mid-frame: assert i_Rst_n=0 at v=200, h=300. Outputs go to reset values immediately (async). After release, o_Frame_Start is seen after 3 clocks and a custom palette entry reads as its default.
- With VGA_TILE_GRID_LINES_EN: pixels h=0, h=32 and v=32 render palette 15 (111/111/111); h=1, v=1 renders the tile colour.
